// File: rtl/token_ring_ctrl_if.sv
// Bus between the token ring node controller and its neighbours: ring RX
// decoder, ring TX encoder and node core. The master modport is the
// controller side; the slave modport is the environment side.
interface token_ring_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              rx_has_data;
  logic [2:0]        rx_type;
  logic [ADDR_W-1:0] rx_addr;
  logic              bad_decode;
  logic              rx_ready;
  logic              tx_ready;
  logic              tx_load;
  logic [1:0]        tx_data_select;
  logic              tx_nack;
  logic              Packet_From_Node_Valid;
  logic              Core_Load_Ack;
  logic              Packet_To_Node_Valid;
  logic              pkt_dropped;
  logic              token_held;

  modport master (
    input  rx_has_data, rx_type, rx_addr, bad_decode, tx_ready,
           Packet_From_Node_Valid,
    output rx_ready, tx_load, tx_data_select, tx_nack, Core_Load_Ack,
           Packet_To_Node_Valid, pkt_dropped, token_held
  );

  modport slave (
    output rx_has_data, rx_type, rx_addr, bad_decode, tx_ready,
           Packet_From_Node_Valid,
    input  rx_ready, tx_load, tx_data_select, tx_nack, Core_Load_Ack,
           Packet_To_Node_Valid, pkt_dropped, token_held
  );
endinterface

// File: rtl/token_ring_ctrl.sv
// Token ring node controller: forwards ring traffic, delivers packets
// addressed to this node and answers them with ACK/NACK, owns the token and
// sends up to TOKEN_HOLD core packets per visit with ACK timeout and bounded
// retry. All outputs are registered; pulses last exactly one cycle.
// Optional feature macro: TOKEN_REGEN_EN -- the master node (NODE_ADDR==0)
// regenerates a lost token after LOST_TMO idle LISTEN cycles. Without it no
// watchdog counter is built.
module token_ring_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int NODE_ADDR  = 1,
  parameter int MAX_RETRY  = 3,
  parameter int ACK_TMO    = 64,
  parameter int TOKEN_HOLD = 2,
  parameter int LOST_TMO   = 1024
) (
  input logic Clk_R,
  input logic Rst_R,
  token_ring_ctrl_if.master bus
);

  localparam logic [2:0] TY_TOKEN  = 3'b111;
  localparam logic [2:0] TY_ACK    = 3'b000;
  localparam logic [2:0] TY_NACK   = 3'b011;
  localparam logic [2:0] TY_DATA_C = 3'b010;
  localparam logic [2:0] TY_DATA_3 = 3'b001;

  localparam logic [1:0] SEL_TOKEN = 2'b00;
  localparam logic [1:0] SEL_FWD   = 2'b01;
  localparam logic [1:0] SEL_NODE  = 2'b10;
  localparam logic [1:0] SEL_REPLY = 2'b11;

  localparam int TMO_W  = $clog2(ACK_TMO + 1);
  localparam int SENT_W = $clog2(TOKEN_HOLD + 1);
  localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(NODE_ADDR);
  localparam logic IS_MASTER = (NODE_ADDR == 0);

  if (MAX_RETRY < 1 || MAX_RETRY > 15 || ACK_TMO < 2 || ACK_TMO > 65535 ||
      TOKEN_HOLD < 1 || TOKEN_HOLD > 15 || LOST_TMO < 2) begin : g_param_check
    $error("token_ring_ctrl: parameter out of range");
  end

  typedef enum logic [3:0] {
    INIT, LISTEN, CHECK, FORWARD, REPLY, RX_DONE,
    HAVE_TOKEN, SEND, WAIT_ACK, ERR
  } state_t;

  state_t              state;
  logic [3:0]          retry_cnt;
  logic [SENT_W-1:0]   sent_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                reply_nack;

  logic                rx_ready_r;
  logic                tx_load_r;
  logic [1:0]          tx_sel_r;
  logic                tx_nack_r;
  logic                core_ack_r;
  logic                to_node_r;
  logic                dropped_r;
  logic                token_held_r;

  // A packet whose rx_ready pulse is on the bus this cycle is already
  // consumed; the decoder only drops rx_has_data after this edge.
  logic rx_valid;
  logic rx_is_data;
  logic rx_to_us;
  logic nack_to_us;
  logic regen;

  assign rx_valid   = bus.rx_has_data & ~rx_ready_r;
  assign rx_is_data = (bus.rx_type == TY_DATA_C) | (bus.rx_type == TY_DATA_3);
  assign rx_to_us   = (bus.rx_addr == MY_ADDR);
  assign nack_to_us = rx_valid & (bus.rx_type == TY_NACK) & rx_to_us;

  function automatic logic [SENT_W-1:0] sent_inc(input logic [SENT_W-1:0] c);
    if (c >= SENT_W'(TOKEN_HOLD)) return c;
    return c + SENT_W'(1);
  endfunction

`ifdef TOKEN_REGEN_EN
  localparam int LOST_W = $clog2(LOST_TMO + 1);
  logic [LOST_W-1:0] lost_cnt;

  assign regen = IS_MASTER && (lost_cnt >= LOST_W'(LOST_TMO - 1));

  // Lost-token watchdog: counts master LISTEN cycles, cleared by any rx TOKEN.
  always_ff @(posedge Clk_R or posedge Rst_R) begin
    if (Rst_R) begin
      lost_cnt <= '0;
    end else if (!IS_MASTER) begin
      lost_cnt <= '0;
    end else if (state == CHECK && bus.rx_type == TY_TOKEN) begin
      lost_cnt <= '0;
    end else if (state == LISTEN) begin
      if (regen && !rx_valid)
        lost_cnt <= '0;
      else if (lost_cnt != LOST_W'(LOST_TMO))
        lost_cnt <= lost_cnt + LOST_W'(1);
    end
  end
`else
  assign regen = 1'b0;
`endif

  // Node control FSM with registered handshake outputs.
  always_ff @(posedge Clk_R or posedge Rst_R) begin
    if (Rst_R) begin
      state        <= INIT;
      retry_cnt    <= '0;
      sent_cnt     <= '0;
      tmo_cnt      <= '0;
      reply_nack   <= 1'b0;
      rx_ready_r   <= 1'b0;
      tx_load_r    <= 1'b0;
      tx_sel_r     <= SEL_TOKEN;
      tx_nack_r    <= 1'b0;
      core_ack_r   <= 1'b0;
      to_node_r    <= 1'b0;
      dropped_r    <= 1'b0;
      token_held_r <= 1'b0;
    end else begin
      rx_ready_r <= 1'b0;
      tx_load_r  <= 1'b0;
      core_ack_r <= 1'b0;
      to_node_r  <= 1'b0;
      dropped_r  <= 1'b0;
      case (state)
        INIT: begin
          if (IS_MASTER) begin
            state        <= HAVE_TOKEN;
            token_held_r <= 1'b1;
            sent_cnt     <= '0;
          end else begin
            state <= LISTEN;
          end
        end
        LISTEN: begin
          if (rx_valid) begin
            state <= CHECK;
          end else if (regen) begin
            state        <= HAVE_TOKEN;
            token_held_r <= 1'b1;
            sent_cnt     <= '0;
          end
        end
        CHECK: begin
          if (bus.rx_type == TY_TOKEN) begin
            rx_ready_r   <= 1'b1;
            sent_cnt     <= '0;
            token_held_r <= 1'b1;
            state        <= HAVE_TOKEN;
          end else if (bus.rx_type == TY_ACK || bus.rx_type == TY_NACK ||
                       (rx_is_data && !rx_to_us)) begin
            state <= FORWARD;
          end else if (rx_is_data) begin
            reply_nack <= bus.bad_decode;
            to_node_r  <= ~bus.bad_decode;
            state      <= REPLY;
          end else begin
            rx_ready_r <= 1'b1;
            state      <= LISTEN;
          end
        end
        FORWARD: begin
          if (bus.tx_ready) begin
            tx_load_r <= 1'b1;
            tx_sel_r  <= SEL_FWD;
            tx_nack_r <= 1'b0;
            state     <= RX_DONE;
          end
        end
        REPLY: begin
          if (bus.tx_ready) begin
            tx_load_r <= 1'b1;
            tx_sel_r  <= SEL_REPLY;
            tx_nack_r <= reply_nack;
            state     <= RX_DONE;
          end
        end
        // Release the held packet one cycle after its load so that
        // rx_ready and tx_load never share a cycle.
        RX_DONE: begin
          rx_ready_r <= 1'b1;
          state      <= LISTEN;
        end
        HAVE_TOKEN: begin
          if (bus.Packet_From_Node_Valid && sent_cnt < SENT_W'(TOKEN_HOLD)) begin
            state <= SEND;
          end else if (bus.tx_ready) begin
            tx_load_r    <= 1'b1;
            tx_sel_r     <= SEL_TOKEN;
            tx_nack_r    <= 1'b0;
            token_held_r <= 1'b0;
            state        <= LISTEN;
          end
        end
        SEND: begin
          if (bus.tx_ready) begin
            tx_load_r <= 1'b1;
            tx_sel_r  <= SEL_NODE;
            tx_nack_r <= 1'b0;
            tmo_cnt   <= '0;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (rx_valid && bus.rx_type == TY_ACK && rx_to_us) begin
            rx_ready_r <= 1'b1;
            core_ack_r <= 1'b1;
            sent_cnt   <= sent_inc(sent_cnt);
            retry_cnt  <= '0;
            state      <= HAVE_TOKEN;
          end else if (nack_to_us || tmo_cnt == TMO_W'(ACK_TMO - 1)) begin
            if (nack_to_us)
              rx_ready_r <= 1'b1;
            if (retry_cnt < 4'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= SEND;
            end else begin
              core_ack_r <= 1'b1;
              dropped_r  <= 1'b1;
              retry_cnt  <= '0;
              sent_cnt   <= sent_inc(sent_cnt);
              state      <= HAVE_TOKEN;
            end
          end else if (rx_valid) begin
            rx_ready_r <= 1'b1;
          end
        end
        ERR: begin
          token_held_r <= 1'b0;
          state        <= LISTEN;
        end
        default: begin
          token_held_r <= 1'b0;
          state        <= LISTEN;
        end
      endcase
    end
  end

  assign bus.rx_ready             = rx_ready_r;
  assign bus.tx_load              = tx_load_r;
  assign bus.tx_data_select       = tx_sel_r;
  assign bus.tx_nack              = tx_nack_r;
  assign bus.Core_Load_Ack        = core_ack_r;
  assign bus.Packet_To_Node_Valid = to_node_r;
  assign bus.pkt_dropped          = dropped_r;
  assign bus.token_held           = token_held_r;

endmodule
